bus_rr_arbiter: RTL and testbench
=================================

// Module: bus_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single SoC slave bus (mux_switch input) among nmasters
//  bus masters (core iport, core dport, UART bootloader). Replaces fixed-priority arbitration:
//  each transaction is granted to one master, held until slave ready/error, then priority
//  rotates. Optional watchdog aborts transactions when the addressed slave never answers.
// PARAMETERS
//  nmasters        3    number of masters (2..8); master i occupies slice [i*W +: W] of packed ports
//  TIMEOUT_CYCLES  255  cycles in BUSY without slave_ready/slave_error before abort (ARB_TIMEOUT_EN only)
// PORTS
//  clk             in   1           bus clock (clk_bus)
//  rst             in   1           asynchronous, active-high reset
//  master_address  in   32*nmasters per-master address
//  master_data_i   in   32*nmasters per-master write data
//  master_wr       in   4*nmasters  per-master byte write enables (0 = read)
//  master_enable   in   nmasters    request; held high with stable addr/data/wr until ready/error
//  master_data_o   out  32          read data, broadcast to all masters (= slave_data_i)
//  master_ready    out  nmasters    one-hot completion pulse to granted master
//  master_error    out  nmasters    one-hot error pulse to granted master
//  slave_data_i    in   32          read data from mux_switch
//  slave_ready     in   1           transaction done
//  slave_error     in   1           decode/bus error
//  slave_address   out  32          granted master address
//  slave_data_o    out  32          granted master write data
//  slave_wr        out  4           granted master byte enables
//  slave_enable    out  1           request to mux_switch
// BEHAVIOUR
//  - Reset (async): state=IDLE, grant=0, last_grant=nmasters-1 (master 0 has first priority);
//    slave_enable, slave_address, slave_data_o, slave_wr, master_ready, master_error all 0.
//  - FSM IDLE: if any master_enable, select first requester scanning (last_grant+1) mod nmasters
//    upward with wrap; register grant, go BUSY. No request: stay IDLE. Arbitration latency 1 cycle.
//  - FSM BUSY: slave_enable = master_enable[grant]; slave_address/data_o/wr muxed from grant
//    (all 0 in IDLE). slave_ready -> master_ready[grant]=1 same cycle (combinational); slave_error
//    -> master_error[grant]=1 same cycle; either -> last_grant<=grant, IDLE.
//  - Both slave_ready and slave_error high: error wins; ready suppressed.
//  - Granted master drops enable in BUSY (abort): slave_enable falls same cycle, no ready/error,
//    last_grant<=grant, IDLE.
//  - Mandatory IDLE cycle between transactions: back-to-back grants 2 cycles apart minimum.
//  - Requests of non-granted masters are never acknowledged; they wait (no starvation: any
//    requester is granted within nmasters transactions).
//  - master_data_o is an unregistered pass-through; only the granted master samples it.
//  - Reset mid-BUSY: outputs drop asynchronously, no ready/error delivered.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: counter (clog2(TIMEOUT_CYCLES+1) bits) clears on entering BUSY,
//    increments each BUSY cycle; when it reaches TIMEOUT_CYCLES with no ready/error,
//    master_error[grant]=1 for one cycle, slave_enable=0 that cycle, last_grant<=grant, IDLE.
//    Ready/error on the expiry cycle take precedence over timeout.
//  ARB_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; TIMEOUT_CYCLES ignored.
// TESTING
//  T1 single master: m1 read 0x0000_0010, slave_ready 2 cycles after slave_enable ->
//     slave_address=0x10, slave_wr=0, master_ready=3'b010 one cycle, master_data_o=slave_data_i.
//  T2 contention: m0,m1,m2 request continuously from reset -> grant order 0,1,2,0,1,2;
//     each grant starts 2 cycles after previous completion.
//  T3 write routing: m2 writes 0xDEAD_BEEF wr=4'b0011 to 0x1000_0004 while m0 idle ->
//     slave_data_o=0xDEAD_BEEF, slave_wr=4'b0011; ready only on master_ready[2].
//  T4 error: slave_error and slave_ready together for m1 -> master_error=3'b010, master_ready=0.
//  T5 reset mid-transaction: assert rst in BUSY for m0 -> slave_enable=0 immediately; after
//     release, m1 and m0 both requesting -> m0 granted first.
//  T6 (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) m0 to unmapped slave, slave_ready never ->
//     master_error[0] pulse 8 cycles after grant, then pending m1 granted.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one slave bus among nmasters bus masters.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_rr_arbiter #(
  parameter int nmasters       = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [32*nmasters-1:0] master_address,
  input  logic [32*nmasters-1:0] master_data_i,
  input  logic [4*nmasters-1:0]  master_wr,
  input  logic [nmasters-1:0]    master_enable,
  output logic [31:0]            master_data_o,
  output logic [nmasters-1:0]    master_ready,
  output logic [nmasters-1:0]    master_error,
  input  logic [31:0]            slave_data_i,
  input  logic                   slave_ready,
  input  logic                   slave_error,
  output logic [31:0]            slave_address,
  output logic [31:0]            slave_data_o,
  output logic [3:0]             slave_wr,
  output logic                   slave_enable
);

  localparam int GW = (nmasters > 1) ? $clog2(nmasters) : 1;

  if (nmasters < 2 || nmasters > 8) begin : g_bad_n
    $error("bus_rr_arbiter: nmasters out of range");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_to
    $error("bus_rr_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_last_grant;

  logic          w_busy;
  logic          w_en;
  logic          w_done;
  logic          w_found;
  logic          w_timeout;
  logic [GW-1:0] w_next;
  int            w_idx;

  assign w_busy = (r_state == S_BUSY);
  assign w_en   = w_busy && master_enable[r_grant];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  assign w_timeout = w_en && !slave_ready && !slave_error
                  && (r_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // Dropped enable is an abort: finish without acknowledging
  assign w_done = !w_en || slave_ready || slave_error || w_timeout;

  // Descending scan so the nearest requester after last_grant wins
  always_comb begin
    w_found = 1'b0;
    w_next  = r_last_grant;
    w_idx   = 0;
    for (int k = nmasters; k >= 1; k--) begin
      w_idx = (int'(r_last_grant) + k) % nmasters;
      if (master_enable[w_idx]) begin
        w_found = 1'b1;
        w_next  = GW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(nmasters - 1);
`ifdef ARB_TIMEOUT_EN
      r_cnt        <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_next;
            r_state <= S_BUSY;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign master_data_o = slave_data_i;

  always_comb begin
    slave_address = '0;
    slave_data_o  = '0;
    slave_wr      = '0;
    slave_enable  = 1'b0;
    master_ready  = '0;
    master_error  = '0;
    if (w_busy) begin
      slave_address = master_address[int'(r_grant)*32 +: 32];
      slave_data_o  = master_data_i[int'(r_grant)*32 +: 32];
      slave_wr      = master_wr[int'(r_grant)*4 +: 4];
      slave_enable  = w_en && !w_timeout;
      master_error[r_grant] = w_en && (slave_error || w_timeout);
      master_ready[r_grant] = w_en && slave_ready && !slave_error;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench for bus_rr_arbiter with three masters.
module tb_bus_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [95:0] maddr;
  logic [95:0] mdat;
  logic [11:0] mwr;
  logic [2:0]  men;
  logic [31:0] mdo;
  logic [2:0]  mrdy;
  logic [2:0]  merr;
  logic [31:0] sdi;
  logic        srdy;
  logic        serr;
  logic [31:0] saddr;
  logic [31:0] sdo;
  logic [3:0]  swr;
  logic        sen;

  int checks;
  int failures;

  bus_rr_arbiter #(
    .nmasters(3),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master_address(maddr),
    .master_data_i(mdat),
    .master_wr(mwr),
    .master_enable(men),
    .master_data_o(mdo),
    .master_ready(mrdy),
    .master_error(merr),
    .slave_data_i(sdi),
    .slave_ready(srdy),
    .slave_error(serr),
    .slave_address(saddr),
    .slave_data_o(sdo),
    .slave_wr(swr),
    .slave_enable(sen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] w);
    maddr[i*32 +: 32] = a;
    mdat[i*32 +: 32]  = d;
    mwr[i*4 +: 4]     = w;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    men = '0;
    srdy = 1'b0;
    serr = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    maddr = '0;
    mdat = '0;
    mwr = '0;
    sdi = '0;
    set_m(0, 32'hA000_0000, 32'h0, 4'h0);
    set_m(1, 32'h0000_0010, 32'h0, 4'h0);
    set_m(2, 32'hC000_0000, 32'h0, 4'h0);
    do_reset();

    chk("rst_en", 32'(sen), 32'h0);
    chk("rst_addr", saddr, 32'h0);
    chk("rst_rdy", 32'(mrdy), 32'h0);
    chk("rst_err", 32'(merr), 32'h0);

    // T1: single read from m1
    men = 3'b010;
    tick();
    chk("t1_en", 32'(sen), 32'h1);
    chk("t1_addr", saddr, 32'h10);
    chk("t1_wr", 32'(swr), 32'h0);
    chk("t1_rdy0", 32'(mrdy), 32'h0);
    tick();
    srdy = 1'b1;
    sdi = 32'hCAFE_1234;
    #1;
    chk("t1_rdy", 32'(mrdy), 32'h2);
    chk("t1_data", mdo, 32'hCAFE_1234);
    tick();
    srdy = 1'b0;
    men = 3'b000;
    #1;
    chk("t1_idle_en", 32'(sen), 32'h0);
    chk("t1_idle_rdy", 32'(mrdy), 32'h0);

    // T2: contention from reset, order 0,1,2,0,1,2
    do_reset();
    men = 3'b111;
    tick();
    for (int t = 0; t < 6; t++) begin
      int e;
      e = t % 3;
      chk($sformatf("t2_en%0d", t), 32'(sen), 32'h1);
      chk($sformatf("t2_addr%0d", t), saddr, maddr[e*32 +: 32]);
      srdy = 1'b1;
      #1;
      chk($sformatf("t2_rdy%0d", t), 32'(mrdy), 32'(1 << e));
      tick();
      srdy = 1'b0;
      #1;
      chk($sformatf("t2_gap%0d", t), 32'(sen), 32'h0);
      tick();
    end
    men = 3'b000;
    srdy = 1'b0;
    tick();
    tick();

    // T3: write from m2 only
    set_m(2, 32'h1000_0004, 32'hDEAD_BEEF, 4'b0011);
    men = 3'b100;
    tick();
    chk("t3_addr", saddr, 32'h1000_0004);
    chk("t3_data", sdo, 32'hDEAD_BEEF);
    chk("t3_wr", 32'(swr), 32'h3);
    srdy = 1'b1;
    #1;
    chk("t3_rdy", 32'(mrdy), 32'h4);
    tick();
    srdy = 1'b0;
    men = 3'b000;
    tick();

    // T4: error and ready together for m1
    men = 3'b010;
    tick();
    srdy = 1'b1;
    serr = 1'b1;
    #1;
    chk("t4_err", 32'(merr), 32'h2);
    chk("t4_rdy", 32'(mrdy), 32'h0);
    tick();
    srdy = 1'b0;
    serr = 1'b0;
    men = 3'b000;
    tick();

    // Abort: m0 drops enable while granted
    men = 3'b001;
    tick();
    chk("ab_en1", 32'(sen), 32'h1);
    men = 3'b000;
    srdy = 1'b1;
    #1;
    chk("ab_en0", 32'(sen), 32'h0);
    chk("ab_rdy", 32'(mrdy), 32'h0);
    tick();
    srdy = 1'b0;
    // last_grant is now 0, so m1 precedes m0
    men = 3'b011;
    tick();
    tick();
    chk("ab_next", saddr, maddr[63:32]);
    men = 3'b000;
    tick();
    tick();

    // T5: reset during BUSY for m0
    men = 3'b001;
    tick();
    chk("t5_en1", 32'(sen), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_en0", 32'(sen), 32'h0);
    chk("t5_addr0", saddr, 32'h0);
    tick();
    rst = 1'b0;
    men = 3'b011;
    tick();
    chk("t5_grant", saddr, maddr[31:0]);
    men = 3'b000;
    tick();
    tick();

`ifdef ARB_TIMEOUT_EN
    // T6: m0 never answered, m1 pending
    do_reset();
    men = 3'b011;
    tick();
    for (int k = 1; k < 8; k++) begin
      tick();
      chk($sformatf("t6_wait%0d", k), 32'(merr), 32'h0);
    end
    tick();
    chk("t6_err", 32'(merr), 32'h1);
    chk("t6_en", 32'(sen), 32'h0);
    tick();
    men = 3'b010;
    tick();
    chk("t6_next", saddr, maddr[63:32]);
    men = 3'b000;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
